bcd_code_counter: RTL and testbench

Parametrised multi-digit synchronous decade counter with a selectable weighted output code (8421, 2421 or excess-3). It generalises the team's single-digit 2421 counter: N cascaded BCD digits, count enable, parallel load with digit validation, terminal-count flag, and an optional down-count mode. It sits in the display and timing paths, feeding 7-segment decoders and downstream counter stages through `tc`.

---
 rtl/bcd_code_counter.sv | 126 ++++++++++++
 tb/tb_bcd_code_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_code_counter.sv
// Multi-digit decade counter with 8421 / 2421 / excess-3 output code.
// Define BCDCNT_DOWN_EN to add the dn port and down counting.
module bcd_code_counter #(
  parameter int DIGITS = 2,
  parameter int CODE   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`ifdef BCDCNT_DOWN_EN
  input  logic                dn,
`endif
  output logic [4*DIGITS-1:0] count_bcd,
  output logic [4*DIGITS-1:0] count_code,
  output logic                tc,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  if (CODE < 0 || CODE > 2) begin : g_bad_code
    $error("bcd_code_counter: CODE must be 0, 1 or 2");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_code_counter: DIGITS must be 1..8");
  end

  function automatic logic [3:0] to_code(input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (CODE == 1) begin
      r = (d > 4'd4) ? d + 4'd6 : d;
    end else if (CODE == 2) begin
      r = d + 4'd3;
    end
    return r;
  endfunction

  logic [W-1:0] ld_val;
  logic         ld_bad;
  logic [W-1:0] up_nxt;
  logic         up_c;
  logic [W-1:0] nxt;
  logic         term;
  logic [W-1:0] code_nxt;
  logic [W-1:0] zero_code;

  // Out-of-range load digits become 0; valid neighbours still load.
  always_comb begin
    ld_val = '0;
    ld_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) begin
        ld_bad = 1'b1;
      end else begin
        ld_val[4*k +: 4] = load_val[4*k +: 4];
      end
    end
  end

  // Ripple carry: a digit moves only when all lower digits are 9.
  always_comb begin
    up_nxt = count_bcd;
    up_c   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (up_c) begin
        up_nxt[4*k +: 4] = (count_bcd[4*k +: 4] == 4'd9) ?
                           4'd0 : count_bcd[4*k +: 4] + 4'd1;
      end
      up_c = up_c & (count_bcd[4*k +: 4] == 4'd9);
    end
  end

`ifdef BCDCNT_DOWN_EN
  logic [W-1:0] dn_nxt;
  logic         dn_c;

  always_comb begin
    dn_nxt = count_bcd;
    dn_c   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (dn_c) begin
        dn_nxt[4*k +: 4] = (count_bcd[4*k +: 4] == 4'd0) ?
                           4'd9 : count_bcd[4*k +: 4] - 4'd1;
      end
      dn_c = dn_c & (count_bcd[4*k +: 4] == 4'd0);
    end
  end

  assign nxt  = dn ? dn_nxt : up_nxt;
  assign term = dn ? dn_c : up_c;
`else
  assign nxt  = up_nxt;
  assign term = up_c;
`endif

  always_comb begin
    code_nxt  = '0;
    zero_code = '0;
    for (int k = 0; k < DIGITS; k++) begin
      code_nxt[4*k +: 4]  = to_code(count_bcd[4*k +: 4]);
      zero_code[4*k +: 4] = to_code(4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_bcd  <= '0;
      count_code <= zero_code;
      load_err   <= 1'b0;
    end else begin
      count_code <= code_nxt;
      load_err   <= load & ld_bad;
      if (load) begin
        count_bcd <= ld_val;
      end else if (en) begin
        count_bcd <= nxt;
      end
    end
  end

  assign tc = rst & en & ~load & term;

endmodule

// File: tb/tb_bcd_code_counter.sv
// Bench for bcd_code_counter: vector table plus random run
// against an integer reference model, three parameter sets.
module tb_bcd_code_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [11:0] lv;
  logic        dn;

  logic [7:0]  b1, c1, b2, c2;
  logic [11:0] b0, c0;
  logic        t1, t2, t0, e1, e2, e0;

  int total = 0;
  int bad   = 0;

  bcd_code_counter #(.DIGITS(2), .CODE(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv[7:0]),
`ifdef BCDCNT_DOWN_EN
    .dn(dn),
`endif
    .count_bcd(b1), .count_code(c1), .tc(t1), .load_err(e1)
  );

  bcd_code_counter #(.DIGITS(2), .CODE(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv[7:0]),
`ifdef BCDCNT_DOWN_EN
    .dn(dn),
`endif
    .count_bcd(b2), .count_code(c2), .tc(t2), .load_err(e2)
  );

  bcd_code_counter #(.DIGITS(3), .CODE(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv),
`ifdef BCDCNT_DOWN_EN
    .dn(dn),
`endif
    .count_bcd(b0), .count_code(c0), .tc(t0), .load_err(e0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counter value as a plain integer.
  int m2, cv2, m3, cv3;
  bit er2, er3;
  logic t1_s;
  int aik[10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};

  function automatic int bcd_of(input int v, input int d);
    int r, p;
    r = 0;
    p = 1;
    for (int i = 0; i < d; i++) begin
      r = r | (((v / p) % 10) << (4 * i));
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int code_of(input int v, input int d, input int code);
    int r, p, dig, x;
    r = 0;
    p = 1;
    for (int i = 0; i < d; i++) begin
      dig = (v / p) % 10;
      x = (code == 0) ? dig : (code == 1) ? aik[dig] : dig + 3;
      r = r | (x << (4 * i));
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int load_of(input logic [11:0] v, input int d,
                                 output bit bd);
    int r, p, dig;
    r = 0;
    p = 1;
    bd = 0;
    for (int i = 0; i < d; i++) begin
      dig = int'(v[4*i +: 4]);
      if (dig > 9) begin
        bd = 1;
        dig = 0;
      end
      r = r + dig * p;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, x);
    end
  endtask

  task automatic upd(inout int m, inout int cv, inout bit er,
                     input int n, input int d);
    bit bd;
    int lval;
    lval = load_of(lv, d, bd);
    if (!rst) begin
      m = 0;
      cv = 0;
      er = 0;
    end else begin
      cv = m;
      er = load && bd;
      if (load) m = lval;
      else if (en) m = dn ? (m + n - 1) % n : (m + 1) % n;
    end
  endtask

  task automatic tick();
    logic x2, x3;
    #1;
    x2 = rst && en && !load && (dn ? m2 == 0 : m2 == 99);
    x3 = rst && en && !load && (dn ? m3 == 0 : m3 == 999);
    t1_s = t1;
    chk("tc_u1", t1, x2);
    chk("tc_u2", t2, x2);
    chk("tc_u0", t0, x3);
    @(posedge clk);
    upd(m2, cv2, er2, 100, 2);
    upd(m3, cv3, er3, 1000, 3);
    #1;
    chk("bcd_u1", b1, bcd_of(m2, 2));
    chk("code_u1", c1, code_of(cv2, 2, 1));
    chk("err_u1", e1, er2);
    chk("bcd_u2", b2, bcd_of(m2, 2));
    chk("code_u2", c2, code_of(cv2, 2, 2));
    chk("err_u2", e2, er2);
    chk("bcd_u0", b0, bcd_of(m3, 3));
    chk("code_u0", c0, code_of(cv3, 3, 0));
    chk("err_u0", e0, er3);
  endtask

  typedef struct packed {
    logic       r;
    logic       e;
    logic       l;
    logic       d;
    logic [7:0] lv;
    logic [7:0] b;
    logic [7:0] c;
    logic       t;
    logic       er;
  } vec_t;

  vec_t rows[$];

  task automatic add(input logic r, e, l, d, input logic [7:0] v, xb, xc,
                     input logic xt, xe);
    vec_t x;
    x.r = r; x.e = e; x.l = l; x.d = d; x.lv = v;
    x.b = xb; x.c = xc; x.t = xt; x.er = xe;
    rows.push_back(x);
  endtask

  initial begin
    m2 = 0; cv2 = 0; m3 = 0; cv3 = 0; er2 = 0; er3 = 0;
    rst = 1'b0; en = 1'b0; load = 1'b0; lv = '0; dn = 1'b0;

    // r e l d  load  bcd    code   tc err  (DIGITS=2, 2421)
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h01, 8'h00, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h02, 8'h01, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h03, 8'h02, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h04, 8'h03, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h05, 8'h04, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h06, 8'h0B, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h07, 8'h0C, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h08, 8'h0D, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h09, 8'h0E, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h10, 8'h0F, 0, 0);
    add(1, 0, 0, 0, 8'h00, 8'h10, 8'h10, 0, 0);
    add(1, 0, 1, 0, 8'h98, 8'h98, 8'h10, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h99, 8'hFE, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1, 1, 1, 0, 8'h3C, 8'h30, 8'h00, 0, 1);
    add(1, 0, 0, 0, 8'h00, 8'h30, 8'h30, 0, 0);
    add(1, 0, 1, 0, 8'hFF, 8'h00, 8'h30, 0, 1);
    add(1, 0, 1, 0, 8'hA5, 8'h05, 8'h00, 0, 1);
    add(1, 0, 0, 0, 8'h00, 8'h05, 8'h0B, 0, 0);
    add(1, 0, 1, 0, 8'h57, 8'h57, 8'h0B, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1, 0, 1, 0, 8'h99, 8'h99, 8'h00, 0, 0);
    add(1, 1, 1, 0, 8'h99, 8'h99, 8'hFF, 0, 0);
    add(1, 0, 0, 0, 8'h00, 8'h99, 8'hFF, 0, 0);
    add(1, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 0);
`ifdef BCDCNT_DOWN_EN
    add(1, 0, 1, 0, 8'h01, 8'h01, 8'h00, 0, 0);
    add(1, 1, 0, 1, 8'h00, 8'h00, 8'h01, 0, 0);
    add(1, 1, 0, 1, 8'h00, 8'h99, 8'h00, 1, 0);
    add(1, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 0);
`endif

    foreach (rows[i]) begin
      rst  = rows[i].r;
      en   = rows[i].e;
      load = rows[i].l;
      dn   = rows[i].d;
      lv   = {4'h0, rows[i].lv};
      tick();
      chk("tbl_tc", t1_s, rows[i].t);
      chk("tbl_bcd", b1, rows[i].b);
      chk("tbl_code", c1, rows[i].c);
      chk("tbl_err", e1, rows[i].er);
    end

    for (int i = 0; i < 500; i++) begin
      rst  = ($urandom_range(0, 39) != 0);
      load = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
`ifdef BCDCNT_DOWN_EN
      dn   = 1'($urandom_range(0, 1));
`endif
      for (int k = 0; k < 3; k++) begin
        lv[4*k +: 4] = ($urandom_range(0, 3) == 0) ?
                       4'($urandom_range(10, 15)) :
                       4'($urandom_range(0, 9));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
